// File: rtl/btn_evt_pkg.sv
// Shared types and defaults for the button event generator.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2,
    ST_REPEAT  = 2'd3
  } btn_state_e;

  localparam int TICK_DIV_1MS_50MHZ = 50000;
  localparam int LONG_MS_DEF        = 500;
  localparam int REPEAT_MS_DEF      = 100;

  // Width of the prescaler count register (counts 0..div-1).
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/btn_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module btn_tick_prescaler
  import btn_evt_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_1MS_50MHZ
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + PW'(1);
    end
  end

  assign tick_o = (cnt_reg == LAST);

endmodule

// File: rtl/btn_event_gen.sv
// Turns debounced button levels into press/release/long/auto-repeat pulses.
// Auto-repeat is present only when BTN_EVT_REPEAT_EN is defined.
module btn_event_gen
  import btn_evt_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int TICK_DIV  = TICK_DIV_1MS_50MHZ,
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] rpt_o,
  output logic [N_BTN-1:0] held_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_MS);
`ifdef BTN_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_CNT    = CNT_W'(REPEAT_MS);
  localparam btn_state_e       AFTER_LONG = ST_REPEAT;
`else
  localparam btn_state_e       AFTER_LONG = ST_HELD;
`endif

  // Reject configurations whose thresholds cannot be represented or reached.
  if (TICK_DIV < 2 || LONG_MS < 1 || REPEAT_MS < 1 ||
      LONG_MS >= (2 ** CNT_W) || REPEAT_MS >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("btn_event_gen: invalid timing parameters");
  end

  logic tick;

  btn_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign tick_o = tick;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    btn_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             long_reg, long_next;

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);

`ifdef BTN_EVT_REPEAT_EN
    logic rpt_reg, rpt_next;
`endif

    always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      long_next    = 1'b0;
`ifdef BTN_EVT_REPEAT_EN
      rpt_next     = 1'b0;
`endif
      if (state_reg == ST_IDLE) begin
        if (btn_i[gi]) begin
          state_next = ST_PRESSED;
          press_next = 1'b1;
          cnt_next   = '0;
        end
      end else if (!btn_i[gi]) begin
        // Release takes priority over any threshold reached this cycle.
        state_next   = ST_IDLE;
        release_next = 1'b1;
        cnt_next     = '0;
      end else if (tick) begin
        case (state_reg)
          ST_PRESSED: begin
            if (cnt_inc >= LONG_CNT) begin
              long_next  = 1'b1;
              cnt_next   = '0;
              state_next = AFTER_LONG;
            end else begin
              cnt_next = cnt_inc;
            end
          end
`ifdef BTN_EVT_REPEAT_EN
          ST_REPEAT: begin
            if (cnt_inc >= RPT_CNT) begin
              rpt_next = 1'b1;
              cnt_next = '0;
            end else begin
              cnt_next = cnt_inc;
            end
          end
`endif
          default: begin
            cnt_next = cnt_reg;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_reg   <= ST_IDLE;
        cnt_reg     <= '0;
        press_reg   <= 1'b0;
        release_reg <= 1'b0;
        long_reg    <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        press_reg   <= press_next;
        release_reg <= release_next;
        long_reg    <= long_next;
      end
    end

`ifdef BTN_EVT_REPEAT_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_reg <= 1'b0;
      end else begin
        rpt_reg <= rpt_next;
      end
    end
    assign rpt_o[gi] = rpt_reg;
`else
    assign rpt_o[gi] = 1'b0;
`endif

    assign press_o[gi]   = press_reg;
    assign release_o[gi] = release_reg;
    assign long_o[gi]    = long_reg;
    assign held_o[gi]    = (state_reg != ST_IDLE);
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench for btn_event_gen: stimulus pushes expected events, a monitor pops them.
module tb_btn_event_gen;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int LM = 3;
  localparam int RM = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_i = '0;
  logic [N-1:0] press_o, release_o, long_o, rpt_o, held_o;
  logic         tick_o;

  always #5 clk = ~clk;

  btn_event_gen #(
    .N_BTN     (N),
    .TICK_DIV  (TD),
    .LONG_MS   (LM),
    .REPEAT_MS (RM),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn_i),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o),
    .rpt_o     (rpt_o),
    .held_o    (held_o),
    .tick_o    (tick_o)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
    logic [N-1:0] rpt;
    logic [N-1:0] held;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   last_rst = 0;
  int   checks   = 0;
  int   errors   = 0;
  bit   done     = 1'b0;

  // cyc = number of rising edges so far; last_rst = last edge that sampled rst high.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) last_rst <= cyc + 1;
  end

  task automatic push(input int c, input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] l, input logic [N-1:0] rp, input logic [N-1:0] h);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.rpt = rp; e.held = h;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: checks tick phase and reset state every cycle, pops the scoreboard on events.
  always @(negedge clk) begin
    logic exp_tick;
    exp_t e;
    if (cyc > 0) begin
      exp_tick = (cyc != last_rst) && (((cyc - last_rst) % TD) == TD - 1);
      checks++;
      if (tick_o !== exp_tick) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick_o, exp_tick);
      end
      if (cyc == last_rst) begin
        checks++;
        if ({press_o, release_o, long_o, rpt_o, held_o} !== '0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d got p=%b r=%b l=%b rp=%b h=%b exp all 0",
                   cyc, press_o, release_o, long_o, rpt_o, held_o);
        end
      end
      if (|{press_o, release_o, long_o, rpt_o}) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got p=%b r=%b l=%b rp=%b exp none",
                   cyc, press_o, release_o, long_o, rpt_o);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || press_o !== e.press || release_o !== e.rel ||
              long_o !== e.lng || rpt_o !== e.rpt || held_o !== e.held) begin
            errors++;
            $display("FAIL event cyc=%0d got p=%b r=%b l=%b rp=%b h=%b exp cyc=%0d p=%b r=%b l=%b rp=%b h=%b",
                     cyc, press_o, release_o, long_o, rpt_o, held_o,
                     e.cyc, e.press, e.rel, e.lng, e.rpt, e.held);
          end else begin
            $display("event cyc=%0d p=%b r=%b l=%b rp=%b h=%b ok",
                     cyc, press_o, release_o, long_o, rpt_o, held_o);
          end
        end
      end
    end
    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_event got none exp cyc=%0d p=%b r=%b l=%b rp=%b",
                 e.cyc, e.press, e.rel, e.lng, e.rpt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    wait_cyc(3);
    rst = 1'b0;

    // Short press on channel 0: five high samples.
    push(101, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(106, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    wait_cyc(100); btn_i = 2'b01;
    wait_cyc(105); btn_i = 2'b00;

    // Long hold on channel 0: 40 high samples.
    push(121, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(131, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
`ifdef BTN_EVT_REPEAT_EN
    push(139, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    push(147, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
    push(155, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
    push(161, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    wait_cyc(120); btn_i = 2'b01;
    wait_cyc(160); btn_i = 2'b00;

    // Release sampled on the same edge as the long-press tick.
    push(201, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(211, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    wait_cyc(200); btn_i = 2'b01;
    wait_cyc(210); btn_i = 2'b00;

    // Reset mid-hold on channel 1, button kept high through reset.
    push(251, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    push(263, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
`ifdef BTN_EVT_REPEAT_EN
    push(271, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
`endif
    push(277, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
    push(286, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
    wait_cyc(250); btn_i = 2'b10;
    wait_cyc(273); rst = 1'b1;
    wait_cyc(276); rst = 1'b0;
    wait_cyc(285); btn_i = 2'b00;

    // Both channels together.
    push(301, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    push(303, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    wait_cyc(300); btn_i = 2'b11;
    wait_cyc(302); btn_i = 2'b00;

    // Single-cycle glitch.
    push(321, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    push(322, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    wait_cyc(320); btn_i = 2'b01;
    wait_cyc(321); btn_i = 2'b00;

    wait_cyc(340);
    done = 1'b1;
  end

endmodule
